rx_uart_oversampled: RTL and testbench

//   UART receiver, 8N1, 16x oversampled by the baud-rate generator tick.

---
 rtl/rx_uart_oversampled.sv | 133 +++++++++++++
 tb/tb_rx_uart_oversampled.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rx_uart_oversampled.sv
// 8N1 UART receiver, oversampled by NUM_TICKS ticks per bit from the baud-rate generator.
// The serial line is resynchronised, each bit is sampled mid-period, and the word is
// assembled LSB first.
module rx_uart_oversampled #(
    parameter int unsigned NBIT_DATA     = 8,
    parameter int unsigned LEN_DATA      = 3,
    parameter int unsigned NUM_TICKS     = 16,
    parameter int unsigned LEN_NUM_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx_bit,
    output logic [NBIT_DATA-1:0] data_out,
    output logic                 rx_done_tick,
    output logic                 frame_err,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    localparam logic [LEN_NUM_TICKS-1:0] TickMid  = LEN_NUM_TICKS'(NUM_TICKS / 2 - 1);
    localparam logic [LEN_NUM_TICKS-1:0] TickLast = LEN_NUM_TICKS'(NUM_TICKS - 1);
    localparam logic [LEN_DATA-1:0]      BitLast  = LEN_DATA'(NBIT_DATA - 1);

    state_t                   r_state, w_state_nxt;
    logic                     r_sync1, r_rx_s;
    logic [LEN_NUM_TICKS-1:0] r_tick_cnt, w_tick_cnt_nxt;
    logic [LEN_DATA-1:0]      r_bit_cnt, w_bit_cnt_nxt;
    logic [NBIT_DATA-1:0]     r_shreg, w_shreg_nxt;
    logic [NBIT_DATA-1:0]     r_data, w_data_nxt;
    logic                     r_frame_err, w_frame_err_nxt;
    logic                     r_done, w_done_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sync flops reset to the idle-high line level so reset never fakes a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_sync1     <= rx_bit;
            r_rx_s      <= r_sync1;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_data      <= w_data_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shreg_nxt     = r_shreg;
        w_data_nxt      = r_data;
        w_frame_err_nxt = r_frame_err;
        w_done_nxt      = 1'b0;
        if (tick) begin
            case (r_state)
                StIdle: begin
                    if (!r_rx_s) begin
                        w_state_nxt    = StStart;
                        w_tick_cnt_nxt = '0;
                    end
                end
                StStart: begin
                    if (r_tick_cnt == TickMid) begin
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                        w_state_nxt    = r_rx_s ? StIdle : StData;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_tick_cnt == TickLast) begin
                        w_shreg_nxt    = {r_rx_s, r_shreg[NBIT_DATA-1:1]};
                        w_tick_cnt_nxt = '0;
                        if (r_bit_cnt == BitLast) begin
                            w_state_nxt = StStop;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                StStop: begin
                    // Leave at mid stop bit so a start bit with no idle gap is still caught.
                    if (r_tick_cnt == TickLast) begin
                        w_data_nxt      = r_shreg;
                        w_frame_err_nxt = ~r_rx_s;
                        w_done_nxt      = 1'b1;
                        w_state_nxt     = StIdle;
                        w_tick_cnt_nxt  = '0;
                        w_bit_cnt_nxt   = '0;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = StIdle;
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy         = (r_state != StIdle);
        data_out     = r_data;
        frame_err    = r_frame_err;
        rx_done_tick = r_done;
    end

endmodule

// File: tb/tb_rx_uart_oversampled.sv
// Directed bench for rx_uart_oversampled: frames driven on the line, outputs checked
// against hand-computed values.
module tb_rx_uart_oversampled;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       rx_bit = 1'b1;
    logic [7:0] data_out;
    logic       rx_done_tick;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int tick_div = 4;
    int tick_cnt = 0;

    int         done_cnt = 0;
    int         wide_cnt = 0;
    int         busy_cyc = 0;
    logic       prev_done = 1'b0;
    logic [7:0] hist [0:15];

    rx_uart_oversampled dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .rx_bit       (rx_bit),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_cnt >= tick_div - 1) begin
            tick     = 1'b1;
            tick_cnt = 0;
        end else begin
            tick     = 1'b0;
            tick_cnt = tick_cnt + 1;
        end
    end

    // Observes done pulses (count, captured word, width) and busy cycles.
    always @(negedge clk) begin
        prev_done <= rx_done_tick;
        if (rx_done_tick) begin
            hist[done_cnt % 16] <= data_out;
            done_cnt            <= done_cnt + 1;
        end
        if (rx_done_tick && prev_done) wide_cnt <= wide_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx_bit = v;
        idle(16 * tick_div);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    int base;
    int bcyc;

    initial begin
        idle(2);
        reset = 1'b0;
        idle(3);
        check("rst_data", 32'(data_out), 32'h00);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(rx_done_tick), 32'h0);
        reset = 1'b1;
        idle(20);

        // 1: clean frame
        base = done_cnt;
        send(8'hA5, 1'b1);
        idle(100);
        check("t1_cnt", 32'(done_cnt - base), 32'd1);
        check("t1_data", 32'(data_out), 32'hA5);
        check("t1_ferr", 32'(frame_err), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: short glitch, rejected at mid start bit
        base = done_cnt;
        bcyc = busy_cyc;
        rx_bit = 1'b0;
        idle(12);
        rx_bit = 1'b1;
        idle(128);
        check("t2_busy_seen", 32'(busy_cyc > bcyc), 32'h1);
        check("t2_cnt", 32'(done_cnt - base), 32'd0);
        check("t2_data", 32'(data_out), 32'hA5);
        check("t2_busy", 32'(busy), 32'h0);

        // 3: framing error, then a good frame
        base = done_cnt;
        send(8'h3C, 1'b0);
        rx_bit = 1'b1;
        idle(256);
        check("t3_cnt_bad", 32'(done_cnt - base), 32'd1);
        check("t3_data_bad", 32'(data_out), 32'h3C);
        check("t3_ferr_bad", 32'(frame_err), 32'h1);
        send(8'h81, 1'b1);
        idle(128);
        check("t3_cnt_good", 32'(done_cnt - base), 32'd2);
        check("t3_data_good", 32'(data_out), 32'h81);
        check("t3_ferr_good", 32'(frame_err), 32'h0);

        // 4: back-to-back frames, no idle gap
        base = done_cnt;
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        idle(128);
        check("t4_cnt", 32'(done_cnt - base), 32'd2);
        check("t4_first", 32'(hist[base % 16]), 32'h00);
        check("t4_second", 32'(hist[(base + 1) % 16]), 32'hFF);
        check("t4_ferr", 32'(frame_err), 32'h0);

        // 5: reset in the middle of data bit 4 of 0x77
        base = done_cnt;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_bit = 1'b1;
        idle(32);
        reset = 1'b0;
        #1;
        check("t5_rst_data", 32'(data_out), 32'h00);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_done", 32'(rx_done_tick), 32'h0);
        check("t5_rst_ferr", 32'(frame_err), 32'h0);
        idle(5);
        reset = 1'b1;
        idle(200);
        check("t5_no_pulse", 32'(done_cnt - base), 32'd0);
        send(8'h5A, 1'b1);
        idle(128);
        check("t5_cnt", 32'(done_cnt - base), 32'd1);
        check("t5_data", 32'(data_out), 32'h5A);

        // 6: tick every clock, 16 clk per bit
        tick_div = 1;
        idle(40);
        base = done_cnt;
        send(8'h96, 1'b1);
        idle(64);
        check("t6_cnt", 32'(done_cnt - base), 32'd1);
        check("t6_data", 32'(data_out), 32'h96);
        check("t6_ferr", 32'(frame_err), 32'h0);

        check("pulse_width", 32'(wide_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
